branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Downstream consumer of the ALU zero-detect result in the EX stage of the pipelined ARM (LEGv8 subset) CPU.
- Holds the architectural NZCV flag register, updated by flag-setting ALU ops (ADDS/SUBS).
- Resolves B, BR, CBZ and B.LT using the live zero flag or the registered flags.
- Produces a registered redirect (taken + target) and a flush window that squashes younger instructions.

Parameters:
- ADDR_W, 64, PC/target width.
- FLUSH_CYCLES, 2, cycles flush stays high after a taken branch (1..7).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX-stage instruction is valid.
- set_flags  in  1  EX instruction writes NZCV (ADDS/SUBS).
- alu_zero  in  1  zero result from the ALU zero-detect.
- alu_neg  in  1  ALU result bit 63.
- alu_ovf  in  1  ALU signed overflow.
- alu_carry  in  1  ALU carry out.
- br_type  in  3  0=none, 1=B, 2=CBZ, 3=B.LT, 4=BR, 5..7 reserved (treated as none).
- pc_ex  in  ADDR_W  PC of the EX instruction.
- br_offset  in  ADDR_W  sign-extended, pre-shifted byte offset.
- reg_target  in  ADDR_W  register value for BR.
- flags  out  4  registered NZCV {N,Z,C,V}.
- br_taken  out  1  registered one-cycle redirect pulse.
- br_target  out  ADDR_W  registered redirect address; valid when br_taken=1.
- flush  out  1  squash IF/ID instructions.

Behaviour:
- Reset (reset=0, async):
  - flags=0, br_taken=0, br_target=0, flush=0.
  - Flush counter=0; FSM in IDLE.
  - Takes effect immediately, including mid-flush; the first edge after release sees IDLE.
- Effective valid: eff_v = ex_valid & (state==IDLE). Instructions arriving while in FLUSH are squashed: no flag update, no branch.
- Flag update: on an edge with eff_v & set_flags, flags <= {alu_neg, alu_zero, alu_carry, alu_ovf}. Otherwise flags hold.
- Condition evaluation (combinational, same cycle):
  - B and BR: always taken.
  - CBZ: taken iff alu_zero=1. The ALU passes the register through, so zero reflects the register.
  - B.LT: taken iff N!=V using the registered flags. An ADDS in cycle t followed by B.LT in cycle t+1 sees the new flags; no bypass is needed because one EX instruction per cycle.
  - A single instruction with set_flags=1 and a branch br_type: the flag update still occurs, and B.LT evaluates the old flags.
- Target:
  - pc_ex + br_offset for B, CBZ and B.LT; reg_target for BR.
  - Modulo 2^ADDR_W; wrap-around is silent.
- Latency: decision registered. br_taken/br_target assert on the edge after the EX cycle and last exactly 1 cycle. br_target holds its last value when not taken.
- FSM:
  - IDLE: on eff_v & taken, go to FLUSH with counter=FLUSH_CYCLES-1 and flush<=1.
  - FLUSH: flush=1; counter decrements each edge. At counter==0 the next edge returns to IDLE and flush<=0.
  - flush is high for exactly FLUSH_CYCLES cycles, starting in the same cycle as br_taken.
- Back-to-back taken branches: the second falls inside the flush window and is squashed, so there is no re-trigger.
- Reserved br_type values: not taken; flags still update if set_flags=1.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined:
  - Adds outputs stat_taken[31:0] and stat_not_taken[31:0].
  - Each counts resolved branches (eff_v with br_type 1..4), split by outcome.
  - Both saturate at 32'hFFFF_FFFF, reset to 0, and exclude squashed instructions.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset mid-flush: B taken, then reset=0 during the second flush cycle -> flush, br_taken and flags drop to 0 immediately (async). After release, B.LT with N=V is not taken.
- CBZ: pc_ex=0x100, br_offset=0x40, alu_zero=1 -> next cycle br_taken=1, br_target=0x140, flush high 2 cycles. Same stimulus with alu_zero=0 -> br_taken=0, flush=0.
- Flags then B.LT: SUBS with neg=1, ovf=0 -> flags=4'b1000. Next cycle B.LT with pc_ex=0x200, br_offset=-8 -> br_target=0x1F8, taken.
- Squash: B taken, followed immediately by ADDS (zero=1) and a second B -> flags unchanged and no second br_taken. After 2 flush cycles, a new B is taken.
- BR and wrap: BR with reg_target=0xDEAD_BEEF -> br_target=0xDEAD_BEEF. B with pc_ex=0xFFFF_FFFF_FFFF_FFF0 and br_offset=0x20 -> br_target=0x10.
- BRANCH_STATS_EN defined: 3 taken and 2 not-taken branches, plus 1 squashed -> stat_taken=3, stat_not_taken=2.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : EX-stage branch resolution. Holds the NZCV flags, resolves
//            B/BR/CBZ/B.LT, and issues a registered redirect plus flush window.
// Options  : `define BRANCH_STATS_EN adds saturating taken/not-taken counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_unit #(
    parameter int ADDR_W       = 64,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              set_flags,
    input  logic              alu_zero,
    input  logic              alu_neg,
    input  logic              alu_ovf,
    input  logic              alu_carry,
    input  logic [2:0]        br_type,
    input  logic [ADDR_W-1:0] pc_ex,
    input  logic [ADDR_W-1:0] br_offset,
    input  logic [ADDR_W-1:0] reg_target,
    output logic [3:0]        flags,
    output logic              br_taken,
    output logic [ADDR_W-1:0] br_target,
    output logic              flush
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]       stat_taken,
    output logic [31:0]       stat_not_taken
`endif
);

    localparam logic [2:0] c_BT_B   = 3'd1;
    localparam logic [2:0] c_BT_CBZ = 3'd2;
    localparam logic [2:0] c_BT_BLT = 3'd3;
    localparam logic [2:0] c_BT_BR  = 3'd4;
    localparam logic [2:0] c_FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic [3:0]        r_flags;
    logic              r_taken;
    logic [ADDR_W-1:0] r_target;
    logic              r_flush;

    logic              w_eff_v;
    logic              w_cond;
    logic              w_take;
    logic [ADDR_W-1:0] w_target;

    always_comb begin
        w_eff_v = ex_valid & (r_state == S_IDLE);
        w_cond  = 1'b0;
        case (br_type)
            c_BT_B:   w_cond = 1'b1;
            c_BT_CBZ: w_cond = alu_zero;
            // B.LT reads the registered flags, never the same-cycle ALU result
            c_BT_BLT: w_cond = r_flags[3] ^ r_flags[0];
            c_BT_BR:  w_cond = 1'b1;
            default:  w_cond = 1'b0;
        endcase
        w_take   = w_eff_v & w_cond;
        w_target = (br_type == c_BT_BR) ? reg_target : (pc_ex + br_offset);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 3'd0;
            r_flags  <= 4'd0;
            r_taken  <= 1'b0;
            r_target <= '0;
            r_flush  <= 1'b0;
        end else begin
            if (w_eff_v & set_flags) begin
                r_flags <= {alu_neg, alu_zero, alu_carry, alu_ovf};
            end
            r_taken <= w_take;
            if (w_take) begin
                r_target <= w_target;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_state <= S_FLUSH;
                        r_cnt   <= c_FLUSH_LAST;
                        r_flush <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= S_IDLE;
                        r_flush <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

    assign flags     = r_flags;
    assign br_taken  = r_taken;
    assign br_target = r_target;
    assign flush     = r_flush;

`ifdef BRANCH_STATS_EN
    logic        w_resolved;
    logic [31:0] r_stat_taken;
    logic [31:0] r_stat_not_taken;

    assign w_resolved = w_eff_v & (br_type >= c_BT_B) & (br_type <= c_BT_BR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stat_taken     <= 32'd0;
            r_stat_not_taken <= 32'd0;
        end else if (w_resolved) begin
            if (w_cond) begin
                if (r_stat_taken != 32'hFFFF_FFFF) r_stat_taken <= r_stat_taken + 32'd1;
            end else begin
                if (r_stat_not_taken != 32'hFFFF_FFFF) r_stat_not_taken <= r_stat_not_taken + 32'd1;
            end
        end
    end

    assign stat_taken     = r_stat_taken;
    assign stat_not_taken = r_stat_not_taken;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed scenarios plus randomized traffic
// checked against a cycle-indexed behavioural model of redirect and flush.
`default_nettype none

module tb_branch_resolve_unit;

    localparam int ADDR_W = 64;
    localparam int FLUSH_CYCLES = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              ex_valid, set_flags, alu_zero, alu_neg, alu_ovf, alu_carry;
    logic [2:0]        br_type;
    logic [ADDR_W-1:0] pc_ex, br_offset, reg_target;
    logic [3:0]        flags;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              flush;
`ifdef BRANCH_STATS_EN
    logic [31:0]       stat_taken, stat_not_taken;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Model: cycle k is the period after edge k; a taken branch in cycle k
    // redirects in cycle k+1 and squashes/flushes cycles k+1..k+FLUSH_CYCLES.
    int              cyc = 0;
    int              busy_until = -1;
    logic [3:0]      m_flags = 4'd0;
    bit              m_taken = 1'b0;
    logic [63:0]     m_target = 64'd0;
    int unsigned     m_st_t = 0, m_st_nt = 0;

    branch_resolve_unit #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .set_flags(set_flags),
        .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_ovf(alu_ovf), .alu_carry(alu_carry),
        .br_type(br_type), .pc_ex(pc_ex), .br_offset(br_offset), .reg_target(reg_target),
        .flags(flags), .br_taken(br_taken), .br_target(br_target), .flush(flush)
`ifdef BRANCH_STATS_EN
        , .stat_taken(stat_taken), .stat_not_taken(stat_not_taken)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_flags = 4'd0; m_taken = 1'b0; m_target = 64'd0;
        busy_until = cyc - 1; m_st_t = 0; m_st_nt = 0;
    endtask

    task automatic tick();
        bit eff, is_br, tk;
        logic [63:0] tgt;
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            eff = ex_valid && (cyc > busy_until);
            is_br = 1'b1; tk = 1'b0;
            tgt = pc_ex + br_offset;
            case (br_type)
                3'd1: tk = 1'b1;
                3'd2: tk = alu_zero;
                3'd3: tk = (m_flags[3] != m_flags[0]);
                3'd4: begin tk = 1'b1; tgt = reg_target; end
                default: is_br = 1'b0;
            endcase
            if (eff && is_br) begin
                if (tk) m_st_t = m_st_t + 1; else m_st_nt = m_st_nt + 1;
            end
            if (eff && set_flags) m_flags = {alu_neg, alu_zero, alu_carry, alu_ovf};
            m_taken = eff && is_br && tk;
            if (m_taken) begin
                m_target = tgt;
                busy_until = cyc + FLUSH_CYCLES;
            end
        end
        cyc = cyc + 1;
        #1;
    endtask

    function automatic bit m_flush();
        return cyc <= busy_until;
    endfunction

    task automatic drive(input bit v, input bit sf, input bit z, input bit n,
                         input bit o, input bit c, input logic [2:0] bt,
                         input logic [63:0] pc, input logic [63:0] off,
                         input logic [63:0] rt);
        ex_valid = v; set_flags = sf; alu_zero = z; alu_neg = n; alu_ovf = o;
        alu_carry = c; br_type = bt; pc_ex = pc; br_offset = off; reg_target = rt;
    endtask

    task automatic idle_n(input int n);
        drive(0, 0, 0, 0, 0, 0, 3'd0, 64'd0, 64'd0, 64'd0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_n(2);
        n_checks++;
        if (flags !== 4'd0 || br_taken !== 1'b0 || br_target !== 64'd0 || flush !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state got flags=%b taken=%b tgt=%h flush=%b exp all zero",
                     flags, br_taken, br_target, flush);
        end
        @(negedge clk); reset = 1'b1;
        idle_n(1);
        n_checks++;
        if (br_taken !== 1'b0 || flush !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release got taken=%b flush=%b exp 0 0", br_taken, flush);
        end
    endtask

    task automatic test_cbz();
        drive(1, 0, 1, 0, 0, 0, 3'd2, 64'h100, 64'h40, 64'd0);
        tick();
        idle_n(0);
        drive(0, 0, 0, 0, 0, 0, 3'd0, 64'd0, 64'd0, 64'd0);
        n_checks++;
        if (br_taken !== 1'b1 || br_target !== 64'h140 || flush !== 1'b1) begin
            n_errors++;
            $display("FAIL cbz_taken got taken=%b tgt=%h flush=%b exp 1 140 1", br_taken, br_target, flush);
        end
        tick();
        n_checks++;
        if (br_taken !== 1'b0 || flush !== 1'b1) begin
            n_errors++;
            $display("FAIL cbz_flush2 got taken=%b flush=%b exp 0 1", br_taken, flush);
        end
        tick();
        n_checks++;
        if (flush !== 1'b0) begin
            n_errors++;
            $display("FAIL cbz_flush_end got flush=%b exp 0", flush);
        end
        drive(1, 0, 0, 0, 0, 0, 3'd2, 64'h100, 64'h40, 64'd0);
        tick();
        n_checks++;
        if (br_taken !== 1'b0 || flush !== 1'b0) begin
            n_errors++;
            $display("FAIL cbz_not_taken got taken=%b flush=%b exp 0 0", br_taken, flush);
        end
        idle_n(1);
    endtask

    task automatic test_flags_blt();
        drive(1, 1, 0, 1, 0, 0, 3'd0, 64'd0, 64'd0, 64'd0);
        tick();
        n_checks++;
        if (flags !== 4'b1000) begin
            n_errors++;
            $display("FAIL subs_flags got %b exp 1000", flags);
        end
        drive(1, 0, 0, 0, 0, 0, 3'd3, 64'h200, -64'sd8, 64'd0);
        tick();
        n_checks++;
        if (br_taken !== 1'b1 || br_target !== 64'h1F8) begin
            n_errors++;
            $display("FAIL blt_taken got taken=%b tgt=%h exp 1 1f8", br_taken, br_target);
        end
        idle_n(2);
    endtask

    task automatic test_squash();
        drive(1, 0, 0, 0, 0, 0, 3'd1, 64'h300, 64'h10, 64'd0);
        tick();
        n_checks++;
        if (br_taken !== 1'b1 || br_target !== 64'h310) begin
            n_errors++;
            $display("FAIL squash_first got taken=%b tgt=%h exp 1 310", br_taken, br_target);
        end
        drive(1, 1, 1, 0, 0, 0, 3'd0, 64'd0, 64'd0, 64'd0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 3'd1, 64'h400, 64'h10, 64'd0);
        n_checks++;
        if (flags !== 4'b1000 || br_taken !== 1'b0 || flush !== 1'b1) begin
            n_errors++;
            $display("FAIL squash_adds got flags=%b taken=%b flush=%b exp 1000 0 1", flags, br_taken, flush);
        end
        tick();
        n_checks++;
        if (flags !== 4'b1000 || br_taken !== 1'b0 || flush !== 1'b0 || br_target !== 64'h310) begin
            n_errors++;
            $display("FAIL squash_b got flags=%b taken=%b flush=%b tgt=%h exp 1000 0 0 310",
                     flags, br_taken, flush, br_target);
        end
        drive(1, 0, 0, 0, 0, 0, 3'd1, 64'h500, 64'h4, 64'd0);
        tick();
        n_checks++;
        if (br_taken !== 1'b1 || br_target !== 64'h504 || flush !== 1'b1) begin
            n_errors++;
            $display("FAIL squash_after got taken=%b tgt=%h flush=%b exp 1 504 1", br_taken, br_target, flush);
        end
        idle_n(2);
    endtask

    task automatic test_br_wrap();
        drive(1, 0, 0, 0, 0, 0, 3'd4, 64'h1000, 64'h8, 64'hDEAD_BEEF);
        tick();
        n_checks++;
        if (br_taken !== 1'b1 || br_target !== 64'hDEAD_BEEF) begin
            n_errors++;
            $display("FAIL br_reg got taken=%b tgt=%h exp 1 deadbeef", br_taken, br_target);
        end
        idle_n(2);
        drive(1, 0, 0, 0, 0, 0, 3'd1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 64'd0);
        tick();
        n_checks++;
        if (br_taken !== 1'b1 || br_target !== 64'h10) begin
            n_errors++;
            $display("FAIL b_wrap got taken=%b tgt=%h exp 1 10", br_taken, br_target);
        end
        idle_n(2);
    endtask

    task automatic test_reset_mid_flush();
        drive(1, 1, 0, 1, 0, 0, 3'd0, 64'd0, 64'd0, 64'd0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 3'd1, 64'h600, 64'h20, 64'd0);
        tick();
        idle_n(1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (flush !== 1'b0 || br_taken !== 1'b0 || flags !== 4'd0 || br_target !== 64'd0) begin
            n_errors++;
            $display("FAIL reset_async got flush=%b taken=%b flags=%b tgt=%h exp 0 0 0 0",
                     flush, br_taken, flags, br_target);
        end
        @(negedge clk); reset = 1'b1;
        idle_n(1);
        drive(1, 0, 0, 0, 0, 0, 3'd3, 64'h700, 64'h40, 64'd0);
        tick();
        n_checks++;
        if (br_taken !== 1'b0 || flush !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_blt got taken=%b flush=%b exp 0 0", br_taken, flush);
        end
        idle_n(1);
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        logic [31:0] base_t, base_nt;
        base_t = stat_taken; base_nt = stat_not_taken;
        drive(1, 0, 0, 0, 0, 0, 3'd1, 64'h10, 64'h10, 64'd0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 3'd1, 64'h20, 64'h10, 64'd0);
        tick();
        idle_n(1);
        drive(1, 0, 0, 0, 0, 0, 3'd2, 64'h30, 64'h10, 64'd0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 3'd3, 64'h40, 64'h10, 64'd0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 3'd4, 64'h50, 64'h10, 64'h88);
        tick();
        idle_n(2);
        drive(1, 0, 1, 0, 0, 0, 3'd2, 64'h60, 64'h10, 64'd0);
        tick();
        idle_n(2);
        n_checks++;
        if (stat_taken - base_t !== 32'd3 || stat_not_taken - base_nt !== 32'd2) begin
            n_errors++;
            $display("FAIL stats_directed got taken+%0d not_taken+%0d exp +3 +2",
                     stat_taken - base_t, stat_not_taken - base_nt);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom});
            tick();
            n_checks++;
            if (br_taken !== m_taken || flush !== m_flush()) begin
                n_errors++;
                $display("FAIL rnd_ctrl cyc=%0d got taken=%b flush=%b exp %b %b",
                         cyc, br_taken, flush, m_taken, m_flush());
            end
            n_checks++;
            if (flags !== m_flags || br_target !== m_target) begin
                n_errors++;
                $display("FAIL rnd_data cyc=%0d got flags=%b tgt=%h exp %b %h",
                         cyc, flags, br_target, m_flags, m_target);
            end
        end
`ifdef BRANCH_STATS_EN
        n_checks++;
        if (stat_taken !== m_st_t || stat_not_taken !== m_st_nt) begin
            n_errors++;
            $display("FAIL rnd_stats got %0d/%0d exp %0d/%0d", stat_taken, stat_not_taken, m_st_t, m_st_nt);
        end
`endif
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 3'd0, 64'd0, 64'd0, 64'd0);
        test_reset();
        test_cbz();
        test_flags_blt();
        test_squash();
        test_br_wrap();
        test_reset_mid_flush();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
